mc_sequencer: RTL and testbench

Sequences multi-cycle operations for the RV32 core: data-memory loads and carry-less multiply (clmul/clmulh). Sits beside the instruction decoder and takes its decoded load/clmul strobes. Owns the pipeline freeze (`stall_o`), the memory request and the multi-cycle unit start. Drives the second-cycle writeback qualifiers `delayed_load`, `delayed_rd` and `delayed_clmul` back into the decoder and the register file. A watchdog aborts any operation whose responder never answers.

---
 rtl/mc_sequencer_pkg.sv | 37 +++
 rtl/mc_sequencer_watchdog.sv | 33 +++
 rtl/mc_sequencer.sv | 117 +++++++++++
 tb/tb_mc_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_sequencer_pkg.sv
// Shared sequencer definitions: state codes, watchdog defaults and the
// writeback-select encoding also consumed by the instruction decoder.
package mc_sequencer_pkg;

    localparam int unsigned SEQ_TIMEOUT_DEFAULT = 63;
    localparam int unsigned SEQ_CNT_W_DEFAULT   = 6;

    typedef logic [2:0] seq_state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_WAIT = 3'd1;
    localparam logic [2:0] ST_LOAD_WB   = 3'd2;
    localparam logic [2:0] ST_MC_RUN    = 3'd3;
    localparam logic [2:0] ST_MC_WB     = 3'd4;

    typedef logic [1:0] wb_sel_t;

    localparam logic [1:0] WB_NONE  = 2'd0;
    localparam logic [1:0] WB_LOAD  = 2'd1;
    localparam logic [1:0] WB_CLMUL = 2'd2;

    function automatic wb_sel_t wb_sel(input seq_state_t st);
        wb_sel_t sel;
        sel = WB_NONE;
        case (st)
            ST_LOAD_WB: sel = WB_LOAD;
            ST_MC_WB:   sel = WB_CLMUL;
            default:    sel = WB_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic is_wait_state(input seq_state_t st);
        return (st == ST_LOAD_WAIT) || (st == ST_MC_RUN);
    endfunction

endpackage

// File: rtl/mc_sequencer_watchdog.sv
// Saturating wait-cycle counter; expired flags the last permitted wait cycle
// so the sequencer can abort on the same edge the limit is reached.
module seq_watchdog
    import mc_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = SEQ_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = SEQ_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle operation sequencer for loads and clmul: owns the pipeline
// stall, request/start pulses, delayed writeback strobes and timeout abort.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = SEQ_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = SEQ_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       clmul_i,
    input  logic [4:0] rd_i,
    input  logic       mem_ready_i,
    input  logic       mc_done_i,
    input  logic       err_clr_i,
    output logic       stall_o,
    output logic       mem_req_o,
    output logic       mc_start_o,
    output logic       delayed_load_o,
    output logic       delayed_clmul_o,
    output logic [4:0] delayed_rd_o,
    output logic       busy_o,
    output logic       err_o
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;
    logic [4:0] r_rd;
    logic       r_err;

    logic       w_idle;
    logic       w_in_wait;
    logic       w_accept_load;
    logic       w_accept_clmul;
    logic       w_expired;
    logic       w_timeout;
    wb_sel_t    w_wb_sel;

    assign w_idle         = (r_state == ST_IDLE);
    assign w_in_wait      = is_wait_state(r_state);
    // An illegal load+clmul decode resolves to the load.
    assign w_accept_load  = w_idle && load_i;
    assign w_accept_clmul = w_idle && clmul_i && !load_i;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept_load || w_accept_clmul),
        .i_en      (w_in_wait),
        .o_expired (w_expired)
    );

    // A responder answering on the final permitted cycle still completes.
    assign w_timeout = w_expired &&
                       (((r_state == ST_LOAD_WAIT) && !mem_ready_i) ||
                        ((r_state == ST_MC_RUN)    && !mc_done_i));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_load) begin
                    w_state_nxt = ST_LOAD_WAIT;
                end else if (w_accept_clmul) begin
                    w_state_nxt = ST_MC_RUN;
                end
            end
            ST_LOAD_WAIT: begin
                if (mem_ready_i) begin
                    w_state_nxt = ST_LOAD_WB;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MC_RUN: begin
                if (mc_done_i) begin
                    w_state_nxt = ST_MC_WB;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD_WB: w_state_nxt = ST_IDLE;
            ST_MC_WB:   w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept_load || w_accept_clmul) begin
                r_rd <= rd_i;
            end
            r_err <= w_timeout || (r_err && !err_clr_i);
        end
    end

    assign w_wb_sel        = wb_sel(r_state);

    assign stall_o         = w_in_wait || w_accept_load || w_accept_clmul;
    assign mem_req_o       = w_accept_load;
    assign mc_start_o      = w_accept_clmul;
    assign delayed_load_o  = (w_wb_sel == WB_LOAD);
    assign delayed_clmul_o = (w_wb_sel == WB_CLMUL);
    assign delayed_rd_o    = (w_wb_sel != WB_NONE) ? r_rd : '0;
    assign busy_o          = !w_idle;
    assign err_o           = r_err;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized directed bench: each operation's expected cycle timeline is
// derived from its kind and responder latency and compared cycle by cycle.
module tb_mc_sequencer;

    localparam int unsigned TMO = 63;

    logic       clk;
    logic       rst;
    logic       load_i;
    logic       clmul_i;
    logic [4:0] rd_i;
    logic       mem_ready_i;
    logic       mc_done_i;
    logic       err_clr_i;
    logic       stall_o;
    logic       mem_req_o;
    logic       mc_start_o;
    logic       delayed_load_o;
    logic       delayed_clmul_o;
    logic [4:0] delayed_rd_o;
    logic       busy_o;
    logic       err_o;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned n_op;
    bit          exp_err;

    mc_sequencer #(
        .TIMEOUT (TMO),
        .CNT_W   (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_i          (load_i),
        .clmul_i         (clmul_i),
        .rd_i            (rd_i),
        .mem_ready_i     (mem_ready_i),
        .mc_done_i       (mc_done_i),
        .err_clr_i       (err_clr_i),
        .stall_o         (stall_o),
        .mem_req_o       (mem_req_o),
        .mc_start_o      (mc_start_o),
        .delayed_load_o  (delayed_load_o),
        .delayed_clmul_o (delayed_clmul_o),
        .delayed_rd_o    (delayed_rd_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1);
    end

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit rclr();
        return ($urandom_range(0, 5) == 0);
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (op %0d): observed %0h expected %0h", tag, n_op, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall_o, 5'd0);
        chk({tag, "_req"}, mem_req_o, 5'd0);
        chk({tag, "_start"}, mc_start_o, 5'd0);
        chk({tag, "_dload"}, delayed_load_o, 5'd0);
        chk({tag, "_dclmul"}, delayed_clmul_o, 5'd0);
        chk({tag, "_drd"}, delayed_rd_o, 5'd0);
        chk({tag, "_busy"}, busy_o, 5'd0);
        chk({tag, "_err"}, err_o, 5'd0);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update err model after the edge.
    task automatic cyc(input bit ld, input bit cm, input logic [4:0] rd,
                       input bit rdy, input bit dn, input bit clr, input bit set,
                       input bit e_stall, input bit e_req, input bit e_start,
                       input bit e_dl, input bit e_dc, input logic [4:0] e_rd,
                       input bit e_busy);
        load_i      = ld;
        clmul_i     = cm;
        rd_i        = rd;
        mem_ready_i = rdy;
        mc_done_i   = dn;
        err_clr_i   = clr;
        @(negedge clk);
        chk("stall", stall_o, 5'(e_stall));
        chk("mem_req", mem_req_o, 5'(e_req));
        chk("mc_start", mc_start_o, 5'(e_start));
        chk("delayed_load", delayed_load_o, 5'(e_dl));
        chk("delayed_clmul", delayed_clmul_o, 5'(e_dc));
        chk("delayed_rd", delayed_rd_o, e_rd);
        chk("busy", busy_o, 5'(e_busy));
        chk("err", err_o, 5'(exp_err));
        @(posedge clk);
        #1;
        if (set) exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
    endtask

    task automatic idle(input int unsigned n, input bit force_done);
        for (int unsigned i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 5'($urandom), rb(), force_done | rb(), rclr(), 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        end
    endtask

    // lat = wait cycle in which the responder answers; lat > TMO means never.
    task automatic do_op(input bit is_ld, input bit both, input logic [4:0] rd,
                         input int unsigned lat, input bit clr_last);
        int unsigned w;
        bit          ld_path;
        n_op++;
        ld_path = is_ld || both;
        w = (lat > TMO) ? TMO : lat;
        cyc(ld_path, !is_ld || both, rd, rb(), rb(), rclr(), 1'b0,
            1'b1, ld_path, !ld_path, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int unsigned k = 1; k <= w; k++) begin
            bit hit;
            bit to;
            hit = (k == lat);
            to  = (lat > TMO) && (k == TMO);
            cyc(rb(), rb(), 5'($urandom),
                ld_path ? hit : rb(), ld_path ? rb() : hit,
                to ? clr_last : rclr(), to,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        end
        if (lat <= TMO) begin
            cyc(rb(), rb(), 5'($urandom), rb(), rb(), rclr(), 1'b0,
                1'b0, 1'b0, 1'b0, ld_path, !ld_path, rd, 1'b1);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        n_op        = 0;
        exp_err     = 1'b0;
        rst         = 1'b0;
        load_i      = 1'b0;
        clmul_i     = 1'b0;
        rd_i        = '0;
        mem_ready_i = 1'b0;
        mc_done_i   = 1'b0;
        err_clr_i   = 1'b0;

        #2;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2, 1'b0);

        // Single load, 1-cycle memory, rd=7; IDLE again in cycle 3.
        do_op(1'b1, 1'b0, 5'd7, 1, 1'b0);
        idle(1, 1'b0);

        // Clmul with a 32-cycle unit, rd=12.
        do_op(1'b0, 1'b0, 5'd12, 32, 1'b0);
        idle(1, 1'b0);

        // Load timeout with a clear in the abort cycle: set must win.
        do_op(1'b1, 1'b0, 5'($urandom), 100, 1'b1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(1, 1'b0);

        // Simultaneous decode resolves to the load.
        do_op(1'b1, 1'b1, 5'd21, 3, 1'b0);

        // Clmul timeout, then a load answered on the last permitted cycle.
        do_op(1'b0, 1'b0, 5'd30, 200, 1'b0);
        do_op(1'b1, 1'b0, 5'd0, TMO, 1'b0);
        idle(2, 1'b0);

        // Reset asserted in MC_RUN cycle 10, then stray mc_done pulses.
        n_op++;
        cyc(1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int unsigned k = 1; k < 10; k++) begin
            cyc(1'b0, 1'b0, 5'd0, rb(), 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        end
        load_i      = 1'b0;
        clmul_i     = 1'b0;
        mc_done_i   = 1'b0;
        mem_ready_i = 1'b0;
        err_clr_i   = 1'b0;
        rst         = 1'b0;
        #1;
        exp_err = 1'b0;
        chk_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3, 1'b1);

        // Back-to-back: load then clmul in the cycle after LOAD_WB.
        do_op(1'b1, 1'b0, 5'd3, 2, 1'b0);
        do_op(1'b0, 1'b0, 5'd17, 4, 1'b0);
        idle(1, 1'b0);

        // Randomized operation stream.
        for (int unsigned i = 0; i < 40; i++) begin
            bit          is_ld;
            bit          both;
            int unsigned lat;
            is_ld = rb();
            both  = ($urandom_range(0, 7) == 0);
            lat   = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70)
                                                : $urandom_range(1, 12);
            do_op(is_ld, both, 5'($urandom), lat, rb());
            idle($urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
